// File: rtl/hop_pkg.sv
// hop_pkg - shared types and helpers for the Hopfield recall engine.
//   hop_state_t : recall FSM states
//   acc_w/addr_w/iter_w/dist_w/idx_w : derived bus widths
//   bipolar     : maps a weight through a bipolar neuron value (+w for 1, -w for 0)
package hop_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SWEEP,
    S_COMPARE,
    S_DONE
  } hop_state_t;

  // Worst-case |sum| is N * 2^(WW-1); one extra bit beyond that keeps the sign.
  function automatic int acc_w(input int n, input int ww);
    return ww + $clog2(n) + 1;
  endfunction

  function automatic int addr_w(input int n);
    return (n * n > 1) ? $clog2(n * n) : 1;
  endfunction

  function automatic int iter_w(input int m);
    return $clog2(m + 1);
  endfunction

  function automatic int dist_w(input int n);
    return $clog2(n + 1);
  endfunction

  function automatic int idx_w(input int p);
    return (p > 1) ? $clog2(p) : 1;
  endfunction

  function automatic logic signed [31:0] bipolar(input logic s, input logic signed [31:0] w);
    return s ? w : -w;
  endfunction

endpackage

// File: rtl/hop_weight_ram.sv
// hop_weight_ram - N*N x WW single-port weight store, one-cycle synchronous read.
//   CLK   in  clock
//   lock  in  high while a recall is running; writes are discarded
//   we    in  write enable
//   addr  in  shared read/write address
//   wdata in  write data
//   rdata out registered read data (mem[addr] from the previous cycle)
// Contents are not reset; they survive RST.
module hop_weight_ram #(
  parameter int DEPTH = 625,
  parameter int AW    = 10,
  parameter int WW    = 5
) (
  input  logic                 CLK,
  input  logic                 lock,
  input  logic                 we,
  input  logic [AW-1:0]        addr,
  input  logic [WW-1:0]        wdata,
  output logic signed [WW-1:0] rdata
);

  logic [WW-1:0] mem [DEPTH];

  always_ff @(posedge CLK) begin
    if (we && !lock) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/hopfield_recall.sv
// hopfield_recall - Hopfield associative-recall engine.
// Loads a probe, sweeps in-place asynchronous neuron updates from the weight RAM
// until a sweep flips nothing or MAX_ITER sweeps ran, then matches the settled
// state against the stored patterns.
// Ports:
//   CLK, RST            clock, asynchronous active-high reset
//   start, probe        begin recall (IDLE only), initial state
//   w_we/w_addr/w_data  weight write, addr = i*N+j (ignored while busy)
//   p_we/p_idx/p_data   pattern write, marks slot valid (ignored while busy)
//   busy, done          recall in progress, one-cycle completion pulse
//   state_out           live neuron state
//   converged           last sweep had no flips (0 = sweep-limit timeout)
//   iter_count          sweeps executed
//   match_valid/match_onehot/match_idx   pattern match results
//   min_dist            (HOP_HAMMING_EN only) Hamming distance of best slot
// Build option: define HOP_HAMMING_EN for nearest-pattern (Hamming) matching;
// otherwise matching is exact.
module hopfield_recall
  import hop_pkg::*;
#(
  parameter int N        = 25,
  parameter int WW       = 5,
  parameter int NPAT     = 4,
  parameter int MAX_ITER = 16,
  localparam int ADDR_W  = addr_w(N),
  localparam int ITER_W  = iter_w(MAX_ITER),
  localparam int IDX_W   = idx_w(NPAT),
  localparam int DIST_W  = dist_w(N)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  input  logic [N-1:0]      probe,
  input  logic              w_we,
  input  logic [ADDR_W-1:0] w_addr,
  input  logic [WW-1:0]     w_data,
  input  logic              p_we,
  input  logic [IDX_W-1:0]  p_idx,
  input  logic [N-1:0]      p_data,
  output logic              busy,
  output logic              done,
  output logic [N-1:0]      state_out,
  output logic              converged,
  output logic [ITER_W-1:0] iter_count,
  output logic              match_valid,
  output logic [NPAT-1:0]   match_onehot,
  output logic [IDX_W-1:0]  match_idx
`ifdef HOP_HAMMING_EN
  ,
  output logic [DIST_W-1:0] min_dist
`endif
);

  localparam int ACC_W = acc_w(N, WW);
  localparam int NRN_W = $clog2(N);
  localparam int CNT_W = $clog2(N + 2);

  hop_state_t state_q, state_d;

  logic [N-1:0]            neur_q;
  logic [NRN_W-1:0]        nrn_q;
  logic [CNT_W-1:0]        col_q;
  logic signed [ACC_W-1:0] acc_q;
  logic [DIST_W-1:0]       flip_q;
  logic [ITER_W-1:0]       iter_q;
  logic                    conv_q;
  logic [NPAT-1:0]         valid_q;
  logic [N-1:0]            pat_q [NPAT];
  logic [IDX_W-1:0]        midx_q;
  logic                    mvalid_q;

  // Weight RAM: the recall owns the address while busy.
  logic [CNT_W-1:0]        rd_col;
  logic [ADDR_W-1:0]       ram_addr;
  logic signed [WW-1:0]    w_rdata;

  assign rd_col   = (col_q < CNT_W'(N)) ? col_q : '0;
  assign ram_addr = busy ? (ADDR_W'(nrn_q) * ADDR_W'(N) + ADDR_W'(rd_col)) : w_addr;

  hop_weight_ram #(.DEPTH(N * N), .AW(ADDR_W), .WW(WW)) u_ram (
    .CLK   (CLK),
    .lock  (busy),
    .we    (w_we),
    .addr  (ram_addr),
    .wdata (w_data),
    .rdata (w_rdata)
  );

  // Read issued at column c returns at c+1, so the term belongs to column c-1.
  logic [CNT_W-1:0]        src_col;
  logic signed [ACC_W-1:0] term;

  assign src_col = col_q - CNT_W'(1);
  assign term    = ACC_W'(bipolar(neur_q[src_col], 32'(w_rdata)));

  logic acc_pos, acc_neg, cur_bit, new_bit, flip;
  logic decide, sweep_end, any_flip, iter_last;

  assign acc_pos   = !acc_q[ACC_W-1] && (acc_q != '0);
  assign acc_neg   = acc_q[ACC_W-1];
  assign cur_bit   = neur_q[nrn_q];
  assign new_bit   = acc_pos | (cur_bit & ~acc_neg);
  assign flip      = new_bit ^ cur_bit;
  assign decide    = (state_q == S_SWEEP) && (col_q == CNT_W'(N + 1));
  assign sweep_end = decide && (nrn_q == NRN_W'(N - 1));
  assign any_flip  = (flip_q != '0) || flip;
  assign iter_last = (iter_q == ITER_W'(MAX_ITER - 1));

  logic cmp_last;

`ifdef HOP_HAMMING_EN
  logic [IDX_W-1:0]  cmp_q;
  logic [DIST_W-1:0] best_q;
  logic [DIST_W-1:0] dist;
  logic [N-1:0]      diff;
  logic              better;

  assign diff = neur_q ^ pat_q[cmp_q];

  always_comb begin
    dist = '0;
    for (int b = 0; b < N; b++) dist = dist + DIST_W'(diff[b]);
  end

  // Strict '<' keeps the lowest index on a tie.
  assign better       = valid_q[cmp_q] && (!mvalid_q || (dist < best_q));
  assign cmp_last     = (cmp_q == IDX_W'(NPAT - 1));
  assign match_onehot = mvalid_q ? (NPAT'(1) << midx_q) : '0;
  assign min_dist     = best_q;
`else
  logic [NPAT-1:0]  mhot_q;
  logic [NPAT-1:0]  hit;
  logic [IDX_W-1:0] hit_idx;

  // Descending scan so the lowest matching index wins.
  always_comb begin
    hit     = '0;
    hit_idx = '0;
    for (int p = NPAT - 1; p >= 0; p--) begin
      hit[p] = valid_q[p] && (neur_q == pat_q[p]);
      if (hit[p]) hit_idx = IDX_W'(p);
    end
  end

  assign cmp_last     = 1'b1;
  assign match_onehot = mhot_q;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      S_IDLE:    if (start) state_d = S_LOAD;
      S_LOAD: begin
        busy    = 1'b1;
        state_d = S_SWEEP;
      end
      S_SWEEP: begin
        busy = 1'b1;
        if (sweep_end && (!any_flip || iter_last)) state_d = S_COMPARE;
      end
      S_COMPARE: begin
        busy = 1'b1;
        if (cmp_last) state_d = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default:   state_d = S_IDLE;
    endcase
  end

  // Pattern data is not reset; only the valid bits are.
  always_ff @(posedge CLK) begin
    if (p_we && !busy) pat_q[p_idx] <= p_data;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      neur_q   <= '0;
      nrn_q    <= '0;
      col_q    <= '0;
      acc_q    <= '0;
      flip_q   <= '0;
      iter_q   <= '0;
      conv_q   <= 1'b0;
      valid_q  <= '0;
      midx_q   <= '0;
      mvalid_q <= 1'b0;
`ifdef HOP_HAMMING_EN
      cmp_q    <= '0;
      best_q   <= '0;
`else
      mhot_q   <= '0;
`endif
    end else begin
      if (p_we && !busy) valid_q[p_idx] <= 1'b1;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            neur_q   <= probe;
            nrn_q    <= '0;
            col_q    <= '0;
            acc_q    <= '0;
            flip_q   <= '0;
            iter_q   <= '0;
            conv_q   <= 1'b0;
            midx_q   <= '0;
            mvalid_q <= 1'b0;
`ifdef HOP_HAMMING_EN
            cmp_q    <= '0;
            best_q   <= '0;
`else
            mhot_q   <= '0;
`endif
          end
        end
        S_SWEEP: begin
          if (col_q == '0)              acc_q <= '0;
          else if (col_q <= CNT_W'(N))  acc_q <= acc_q + term;
          if (decide) begin
            neur_q[nrn_q] <= new_bit;
            col_q         <= '0;
            if (sweep_end) begin
              nrn_q  <= '0;
              flip_q <= '0;
              conv_q <= !any_flip;
              if (iter_q != ITER_W'(MAX_ITER)) iter_q <= iter_q + ITER_W'(1);
            end else begin
              nrn_q  <= nrn_q + NRN_W'(1);
              flip_q <= flip_q + DIST_W'(flip);
            end
          end else begin
            col_q <= col_q + CNT_W'(1);
          end
        end
        S_COMPARE: begin
`ifdef HOP_HAMMING_EN
          if (better) begin
            mvalid_q <= 1'b1;
            midx_q   <= cmp_q;
            best_q   <= dist;
          end
          cmp_q <= cmp_q + IDX_W'(1);
`else
          mhot_q   <= hit;
          midx_q   <= hit_idx;
          mvalid_q <= |hit;
`endif
        end
        default: ;
      endcase
    end
  end

  assign state_out   = neur_q;
  assign converged   = conv_q;
  assign iter_count  = iter_q;
  assign match_valid = mvalid_q;
  assign match_idx   = midx_q;

endmodule

// File: tb/tb_hopfield_recall.sv
// tb_hopfield_recall - directed bench for hopfield_recall (N=25, MAX_ITER=4).
// Build option: HOP_HAMMING_EN switches expectations to nearest-pattern matching.
module tb_hopfield_recall;

`ifdef HOP_HAMMING_EN
  localparam int EXTRA = 3;
`else
  localparam int EXTRA = 0;
`endif
  localparam int SWEEP = 675;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        start = 1'b0;
  logic [24:0] probe = '0;
  logic        w_we = 1'b0;
  logic [9:0]  w_addr = '0;
  logic [4:0]  w_data = '0;
  logic        p_we = 1'b0;
  logic [1:0]  p_idx = '0;
  logic [24:0] p_data = '0;
  logic        busy, done, converged, match_valid;
  logic [24:0] state_out;
  logic [2:0]  iter_count;
  logic [3:0]  match_onehot;
  logic [1:0]  match_idx;
`ifdef HOP_HAMMING_EN
  logic [4:0]  min_dist;
`endif

  int errors = 0;
  int checks = 0;

  always #5 CLK = ~CLK;

  hopfield_recall #(.N(25), .WW(5), .NPAT(4), .MAX_ITER(4)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .start        (start),
    .probe        (probe),
    .w_we         (w_we),
    .w_addr       (w_addr),
    .w_data       (w_data),
    .p_we         (p_we),
    .p_idx        (p_idx),
    .p_data       (p_data),
    .busy         (busy),
    .done         (done),
    .state_out    (state_out),
    .converged    (converged),
    .iter_count   (iter_count),
    .match_valid  (match_valid),
    .match_onehot (match_onehot),
    .match_idx    (match_idx)
`ifdef HOP_HAMMING_EN
    ,
    .min_dist     (min_dist)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr_w(input int a, input logic [4:0] d);
    @(negedge CLK);
    w_we = 1'b1; w_addr = 10'(a); w_data = d;
    @(posedge CLK);
    #1 w_we = 1'b0;
  endtask

  task automatic wr_p(input logic [1:0] idx, input logic [24:0] d);
    @(negedge CLK);
    p_we = 1'b1; p_idx = idx; p_data = d;
    @(posedge CLK);
    #1 p_we = 1'b0;
  endtask

  // mode 0: all zero; mode 1: +1 off-diagonal, 0 on the diagonal
  task automatic fill_w(input int mode);
    for (int i = 0; i < 25; i++)
      for (int j = 0; j < 25; j++)
        wr_w(i * 25 + j, (mode == 1 && i != j) ? 5'd1 : 5'd0);
  endtask

  // cyc = posedges after the start edge until done is seen
  task automatic run(input logic [24:0] p, input bit inj, input bit pw,
                     input logic [1:0] pidx, input logic [24:0] pdat,
                     output int cyc, output logic bmid, output logic dafter, output logic bafter);
    @(negedge CLK);
    probe = p; start = 1'b1;
    if (pw) begin p_we = 1'b1; p_idx = pidx; p_data = pdat; end
    @(posedge CLK);
    #1 start = 1'b0; p_we = 1'b0;
    cyc = 0; bmid = 1'b0;
    while (done !== 1'b1 && cyc < 4000) begin
      @(posedge CLK);
      #1 cyc++;
      if (cyc == 10) bmid = busy;
      if (inj && cyc == 50) begin
        start = 1'b1; probe = 25'h0AAAAAA;
        w_we = 1'b1; w_addr = 10'd1; w_data = 5'b11000;
        p_we = 1'b1; p_idx = 2'd3; p_data = 25'h1;
      end
      if (inj && cyc == 51) begin
        start = 1'b0; w_we = 1'b0; p_we = 1'b0;
      end
    end
    @(posedge CLK);
    #1 dafter = done; bafter = busy;
  endtask

  initial begin
    int   cyc;
    logic bmid, dafter, bafter;

    // reset state
    repeat (2) @(posedge CLK);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_state", state_out, 0);
    check("rst_conv", converged, 0);
    check("rst_iter", iter_count, 0);
    check("rst_mvalid", match_valid, 0);
    check("rst_onehot", match_onehot, 0);
    check("rst_idx", match_idx, 0);
    @(negedge CLK);
    RST = 1'b0;

    // 1: zero weights hold the probe
    fill_w(0);
    run(25'h1555555, 0, 0, 2'd0, 25'h0, cyc, bmid, dafter, bafter);
    check("t1_latency", cyc, 2 + SWEEP + EXTRA);
    check("t1_busy_mid", bmid, 1);
    check("t1_state", state_out, 25'h1555555);
    check("t1_conv", converged, 1);
    check("t1_iter", iter_count, 1);
    check("t1_mvalid", match_valid, 0);
    check("t1_onehot", match_onehot, 0);
    check("t1_done_pulse", dafter, 0);
    check("t1_busy_after", bafter, 0);

    // 5: reset mid-recall, then repeat test 1
    @(negedge CLK);
    probe = 25'h1555555; start = 1'b1;
    @(posedge CLK);
    #1 start = 1'b0;
    repeat (99) @(posedge CLK);
    #1;
    check("t5_busy_pre", busy, 1);
    check("t5_state_pre", state_out, 25'h1555555);
    #2 RST = 1'b1;
    #1;
    check("t5_busy_rst", busy, 0);
    check("t5_done_rst", done, 0);
    check("t5_state_rst", state_out, 0);
    @(negedge CLK);
    RST = 1'b0;
    run(25'h1555555, 0, 0, 2'd0, 25'h0, cyc, bmid, dafter, bafter);
    check("t5_latency", cyc, 2 + SWEEP + EXTRA);
    check("t5_state", state_out, 25'h1555555);
    check("t5_conv", converged, 1);
    check("t5_iter", iter_count, 1);

    // 2: +1 off-diagonal, 20 ones pulls everything to 1
    fill_w(1);
    run(25'h1FFFFE0, 0, 0, 2'd0, 25'h0, cyc, bmid, dafter, bafter);
    check("t2_latency", cyc, 2 + 2 * SWEEP + EXTRA);
    check("t2_state", state_out, 25'h1FFFFFF);
    check("t2_conv", converged, 1);
    check("t2_iter", iter_count, 2);
    check("t2_mvalid", match_valid, 0);

    // 3: pattern 0 written in the same cycle as start
    run(25'h1FFFFE0, 0, 1, 2'd0, 25'h1FFFFFF, cyc, bmid, dafter, bafter);
    check("t3_state", state_out, 25'h1FFFFFF);
    check("t3_mvalid", match_valid, 1);
    check("t3_onehot", match_onehot, 4'b0001);
    check("t3_idx", match_idx, 0);

    // 3b: slots 0 and 2 both match
    wr_p(2'd2, 25'h1FFFFFF);
    run(25'h1FFFFFF, 0, 0, 2'd0, 25'h0, cyc, bmid, dafter, bafter);
    check("t3b_latency", cyc, 2 + SWEEP + EXTRA);
    check("t3b_iter", iter_count, 1);
    check("t3b_mvalid", match_valid, 1);
`ifdef HOP_HAMMING_EN
    check("t3b_onehot", match_onehot, 4'b0001);
    check("t3b_dist", min_dist, 0);
`else
    check("t3b_onehot", match_onehot, 4'b0101);
`endif
    check("t3b_idx", match_idx, 0);

    // 3c: only slot 2 matches
    wr_p(2'd0, 25'h0);
    run(25'h1FFFFFF, 0, 0, 2'd0, 25'h0, cyc, bmid, dafter, bafter);
    check("t3c_onehot", match_onehot, 4'b0100);
    check("t3c_idx", match_idx, 2);
    check("t3c_mvalid", match_valid, 1);

    // 4 + 6: oscillating pair, with start/w_we/p_we injected while busy
    fill_w(0);
    wr_w(1, 5'b00001);
    wr_w(25, 5'b11111);
    run(25'h0, 1, 0, 2'd0, 25'h0, cyc, bmid, dafter, bafter);
    check("t4_latency", cyc, 2 + 4 * SWEEP + EXTRA);
    check("t4_state", state_out, 25'h1);
    check("t4_conv", converged, 0);
    check("t4_iter", iter_count, 4);
`ifdef HOP_HAMMING_EN
    check("t4_mvalid", match_valid, 1);
    check("t4_idx", match_idx, 0);
    check("t4_dist", min_dist, 1);
`else
    check("t4_mvalid", match_valid, 0);
    check("t4_onehot", match_onehot, 0);
`endif
    run(25'h0, 0, 0, 2'd0, 25'h0, cyc, bmid, dafter, bafter);
    check("t6_rerun_latency", cyc, 2 + 4 * SWEEP + EXTRA);
    check("t6_rerun_state", state_out, 25'h1);
    check("t6_rerun_iter", iter_count, 4);

`ifdef HOP_HAMMING_EN
    // 6: probe one bit off pattern 2
    wr_w(1, 5'd0);
    wr_w(25, 5'd0);
    run(25'h1FFFFFE, 0, 0, 2'd0, 25'h0, cyc, bmid, dafter, bafter);
    check("t6h_latency", cyc, 2 + SWEEP + 3);
    check("t6h_dist", min_dist, 1);
    check("t6h_idx", match_idx, 2);
    check("t6h_onehot", match_onehot, 4'b0100);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
